// File: rtl/dmem_arbiter.sv
// Arbitrates the single data-memory port between the CPU MEM stage and the debug/dump requester.
// The CPU has priority, but the debug side is forced in after STARVE_MAX lost conflict cycles.
module dmem_arbiter #(
    parameter int N          = 64,
    parameter int AW         = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [N-1:0]  cpu_wdata,
    output logic [N-1:0]  cpu_rdata,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_lock,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [N-1:0]  dbg_wdata,
    output logic          dbg_ack,
    output logic          dbg_rvalid,
    output logic [N-1:0]  dbg_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [N-1:0]  mem_wdata,
    input  logic [N-1:0]  mem_rdata
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    typedef enum logic {S_CPU, S_DBG} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  starveCnt_q, starveCnt_d;
    logic [CW-1:0]  cntInc;
    logic           dbgRead;
    logic           dbgRvalid_q;
    logic [N-1:0]   dbgRdata_q;

    // The count includes the current conflict cycle, so DBG wins right after STARVE_MAX CPU wins.
    always_comb begin
        state_d     = state_q;
        starveCnt_d = '0;
        cntInc      = (starveCnt_q == CW'(STARVE_MAX)) ? starveCnt_q : starveCnt_q + 1'b1;
        case (state_q)
            S_CPU: begin
                if (dbg_req) begin
                    if (!cpu_req) begin
                        state_d = S_DBG;
                    end else begin
                        starveCnt_d = cntInc;
                        if (cntInc == CW'(STARVE_MAX)) begin
                            state_d = S_DBG;
                        end
                    end
                end
            end
            S_DBG:   state_d = (dbg_lock && dbg_req) ? S_DBG : S_CPU;
            default: state_d = S_CPU;
        endcase
    end

    always_comb begin
        cpu_rdata = mem_rdata;
        cpu_stall = 1'b0;
        dbg_ack   = 1'b0;
        mem_we    = cpu_req & cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        if (state_q == S_DBG) begin
            cpu_stall = cpu_req;
            dbg_ack   = dbg_req;
            mem_we    = dbg_req & dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
        dbgRead = dbg_ack & ~dbg_we;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q     <= S_CPU;
            starveCnt_q <= '0;
            dbgRvalid_q <= 1'b0;
            dbgRdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            starveCnt_q <= starveCnt_d;
            dbgRvalid_q <= dbgRead;
            if (dbgRead) begin
                dbgRdata_q <= mem_rdata;
            end
        end
    end

    assign dbg_rvalid = dbgRvalid_q;
    assign dbg_rdata  = dbgRdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against an ownership-level reference model and a shadow memory.
module tb_dmem_arbiter;

    localparam int N          = 64;
    localparam int AW         = 64;
    localparam int STARVE_MAX = 4;

    logic          CLOCK_50 = 1'b0;
    logic          reset    = 1'b0;
    logic          cpu_req, cpu_we, dbg_req, dbg_lock, dbg_we;
    logic [AW-1:0] cpu_addr, dbg_addr;
    logic [N-1:0]  cpu_wdata, dbg_wdata;
    logic [N-1:0]  cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
    logic          cpu_stall, dbg_ack, dbg_rvalid, mem_we;
    logic [AW-1:0] mem_addr;

    int errors = 0;
    int checks = 0;

    // Environment memory seen by the DUT, and the model's own view of what it should hold.
    logic [N-1:0] envMem [256];
    logic [N-1:0] refMem [256];

    // Reference model: who owns the port this cycle and how long DBG has been losing.
    bit           dbgOwns    = 1'b0;
    int           lostCycles = 0;
    logic         expRvalid  = 1'b0;
    logic [N-1:0] expRdata   = '0;

    dmem_arbiter #(.N(N), .AW(AW), .STARVE_MAX(STARVE_MAX)) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .dbg_req   (dbg_req),
        .dbg_lock  (dbg_lock),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_ack   (dbg_ack),
        .dbg_rvalid(dbg_rvalid),
        .dbg_rdata (dbg_rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    assign mem_rdata = envMem[mem_addr[7:0]];

    always @(posedge CLOCK_50) begin
        if (mem_we) envMem[mem_addr[7:0]] <= mem_wdata;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        dbgOwns    = 1'b0;
        lostCycles = 0;
        expRvalid  = 1'b0;
        expRdata   = '0;
    endtask

    task automatic driveIdle();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_lock = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    endtask

    // Drives one cycle of inputs, checks every output against the model, then advances the model.
    task automatic applyStimulus(input logic cReq, input logic cWe, input logic [AW-1:0] cAddr,
                                 input logic [N-1:0] cWd, input logic dReq, input logic dLock,
                                 input logic dWe, input logic [AW-1:0] dAddr, input logic [N-1:0] dWd);
        logic [AW-1:0] eAddr;
        logic          eWe;
        logic [N-1:0]  eWd;
        @(negedge CLOCK_50);
        cpu_req = cReq; cpu_we = cWe; cpu_addr = cAddr; cpu_wdata = cWd;
        dbg_req = dReq; dbg_lock = dLock; dbg_we = dWe; dbg_addr = dAddr; dbg_wdata = dWd;
        #1;
        eAddr = dbgOwns ? dAddr : cAddr;
        eWd   = dbgOwns ? dWd : cWd;
        eWe   = dbgOwns ? (dReq & dWe) : (cReq & cWe);
        checkOutput("cpu_stall",  cpu_stall,  dbgOwns & cReq);
        checkOutput("dbg_ack",    dbg_ack,    dbgOwns & dReq);
        checkOutput("mem_we",     mem_we,     eWe);
        checkOutput("mem_addr",   mem_addr,   eAddr);
        checkOutput("mem_wdata",  mem_wdata,  eWd);
        checkOutput("cpu_rdata",  cpu_rdata,  refMem[eAddr[7:0]]);
        checkOutput("dbg_rvalid", dbg_rvalid, expRvalid);
        checkOutput("dbg_rdata",  dbg_rdata,  expRdata);
        expRvalid = dbgOwns & dReq & ~dWe;
        if (expRvalid) expRdata = refMem[dAddr[7:0]];
        if (eWe) refMem[eAddr[7:0]] = eWd;
        if (dbgOwns) begin
            dbgOwns    = dLock & dReq;
            lostCycles = 0;
        end else if (!dReq) begin
            lostCycles = 0;
        end else if (!cReq) begin
            dbgOwns    = 1'b1;
            lostCycles = 0;
        end else begin
            lostCycles++;
            if (lostCycles >= STARVE_MAX) begin
                dbgOwns    = 1'b1;
                lostCycles = 0;
            end
        end
    endtask

    initial begin
        driveIdle();
        for (int i = 0; i < 256; i++) begin
            envMem[i] = N'(i);
            refMem[i] = N'(i);
        end
        #1 reset = 1'b1;
        #1;
        checkOutput("rst_stall",  cpu_stall,  1'b0);
        checkOutput("rst_ack",    dbg_ack,    1'b0);
        checkOutput("rst_rvalid", dbg_rvalid, 1'b0);
        checkOutput("rst_rdata",  dbg_rdata,  64'h0);
        checkOutput("rst_we",     mem_we,     1'b0);
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50) reset = 1'b0;
        modelReset();

        // CPU-only write then read back
        applyStimulus(1, 1, 'h10, 'hAB, 0, 0, 0, 0, 0);
        checkOutput("t1_we", mem_we, 1'b1);
        checkOutput("t1_stall", cpu_stall, 1'b0);
        applyStimulus(1, 0, 'h10, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_rd", cpu_rdata, 64'hAB);

        // DBG-only read: granted after one cycle, data registered the cycle after
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 'h10, 0);
        checkOutput("t2_noack", dbg_ack, 1'b0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 'h10, 0);
        checkOutput("t2_ack", dbg_ack, 1'b1);
        applyStimulus(1, 0, 'h11, 0, 0, 0, 0, 0, 0);
        checkOutput("t2_rvalid", dbg_rvalid, 1'b1);
        checkOutput("t2_rdata", dbg_rdata, 64'hAB);
        checkOutput("t2_cpu", cpu_stall, 1'b0);

        // Sustained conflict: four CPU wins, then one forced DBG slot
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 0, 'h20, 0, 1, 0, 0, 'h10, 0);
            checkOutput($sformatf("t3_ack%0d", i), dbg_ack, (i == 4));
            checkOutput($sformatf("t3_stall%0d", i), cpu_stall, (i == 4));
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Locked dump burst of writes, CPU held off throughout
        applyStimulus(0, 0, 0, 0, 1, 1, 1, 'h40, 'h100);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 0, 'h20, 0, 1, (i < 7), 1, AW'('h40 + i), N'('h100 + i));
            checkOutput($sformatf("t4_ack%0d", i), dbg_ack, 1'b1);
            checkOutput($sformatf("t4_stall%0d", i), cpu_stall, 1'b1);
        end
        applyStimulus(1, 0, 'h43, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_release", cpu_stall, 1'b0);
        checkOutput("t4_data", cpu_rdata, 64'h103);

        // Asynchronous reset in the middle of a locked burst
        applyStimulus(0, 0, 0, 0, 1, 1, 0, 'h41, 0);
        applyStimulus(1, 0, 'h20, 0, 1, 1, 0, 'h41, 0);
        applyStimulus(1, 0, 'h20, 0, 1, 1, 0, 'h41, 0);
        checkOutput("t5_pre_rvalid", dbg_rvalid, 1'b1);
        #2 reset = 1'b1;
        #1;
        checkOutput("t5_ack", dbg_ack, 1'b0);
        checkOutput("t5_rvalid", dbg_rvalid, 1'b0);
        checkOutput("t5_stall", cpu_stall, 1'b0);
        checkOutput("t5_rdata", dbg_rdata, 64'h0);
        modelReset();
        driveIdle();
        @(posedge CLOCK_50);
        @(negedge CLOCK_50) reset = 1'b0;
        applyStimulus(1, 0, 'h20, 0, 1, 1, 0, 'h41, 0);
        checkOutput("t5_cpu_state", cpu_stall, 1'b0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // DBG write withdrawn before grant; starvation count restarts from zero
        applyStimulus(1, 0, 'h30, 0, 1, 0, 1, 'h30, 'hDEAD);
        applyStimulus(1, 0, 'h30, 0, 1, 0, 1, 'h30, 'hDEAD);
        applyStimulus(1, 0, 'h30, 0, 0, 0, 0, 0, 0);
        checkOutput("t6_noack", dbg_ack, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 'h31, 0, 1, 0, 0, 'h30, 0);
            checkOutput($sformatf("t6_ack%0d", i), dbg_ack, (i == 4));
        end
        applyStimulus(1, 0, 'h30, 0, 0, 0, 0, 0, 0);
        checkOutput("t6_mem", cpu_rdata, 64'h30);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 9) < 6), 1'($urandom), {$urandom, 24'h0, 8'($urandom)},
                          {$urandom, $urandom}, 1'($urandom), ($urandom_range(0, 9) < 2),
                          1'($urandom), {$urandom, 24'h0, 8'($urandom)}, {$urandom, $urandom});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
